rice_core_lsu: RTL and testbench
================================

RICE_CORE_LSU -- requirements
Module: rice_core_lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data/address width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered accesses; legal range is 1..4.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: i_clk  input  1  clock; i_rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have the following pipeline request ports: i_valid  input  1; o_ready  output  1; i_access_type  input  2 (NONE=0, STORE=1, LOAD=2); i_access_mode  input  3 (B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110); i_address  input  XLEN; i_store_data  input  XLEN; i_rd  input  5.
REQ-005 The block SHALL have the following memory request ports: o_mem_request_valid  output  1; i_mem_request_ready  input  1; o_mem_write  output  1; o_mem_address  output  XLEN; o_mem_strobe  output  XLEN/8; o_mem_write_data  output  XLEN.
REQ-006 The block SHALL have the following memory response ports: i_mem_response_valid  input  1; i_mem_read_data  input  XLEN.
REQ-007 The block SHALL have the following writeback and status ports: o_wb_valid  output  1; o_wb_rd  output  5; o_wb_data  output  XLEN; o_misaligned  output  1.

Function
REQ-008 A request SHALL be accepted in any cycle where i_valid and o_ready are both 1.
REQ-009 o_ready SHALL be 1 iff the registered outstanding count is less than MAX_OUTSTANDING, and either no memory request is held or i_mem_request_ready is 1.
REQ-010 A request with type NONE SHALL be accepted and discarded, with no side effect.
REQ-011 An accepted LOAD or STORE SHALL drive o_mem_request_valid starting the next cycle, and hold it with all request fields stable until i_mem_request_ready is 1.
REQ-012 o_mem_address SHALL be i_address with its low log2(XLEN/8) bits cleared.
REQ-013 o_mem_strobe SHALL cover the accessed bytes at the byte offset: 1, 2, 4 or 8 bytes for B/H/W/D.
REQ-014 o_mem_write_data SHALL be i_store_data shifted left by offset*8.
REQ-015 For loads, o_mem_strobe SHALL be driven as for a store, and o_mem_write SHALL be 0.
REQ-016 Each accepted LOAD or STORE SHALL push {write, mode, offset, rd} into an in-order tracking FIFO of depth MAX_OUTSTANDING; the outstanding count SHALL increment on push.
REQ-017 Memory responses SHALL arrive in request order; each i_mem_response_valid pulse SHALL pop one entry and decrement the count.
REQ-018 A simultaneous push and pop SHALL leave the count unchanged; count SHALL never exceed MAX_OUTSTANDING.
REQ-019 A response to a STORE entry SHALL be consumed without writeback.
REQ-020 A response to a LOAD entry SHALL produce o_wb_valid=1 for exactly one cycle, the cycle after the response.
REQ-021 For a LOAD writeback, o_wb_rd SHALL be the entry's rd, and o_wb_data SHALL be i_mem_read_data shifted right by offset*8, then sign-extended (B/H/W) or zero-extended (BU/HU/WU/D) from the access size.
REQ-022 A response arriving while count is 0 SHALL be ignored.
REQ-023 When XLEN=32, modes D and WU SHALL be treated as W.

Reset
REQ-024 While i_rst is 1 at a clock edge, all of the following SHALL be cleared: FIFO pointers, count, held request, o_mem_request_valid, o_wb_valid and o_misaligned.
REQ-025 The first cycle after reset SHALL have o_ready=1.
REQ-026 In-flight accesses SHALL be abandoned on reset; their later responses SHALL be ignored per REQ-022.

Configuration
REQ-027 The feature SHALL be controlled by macro RICE_CORE_LSU_MISALIGN_TRAP_EN.
REQ-028 With RICE_CORE_LSU_MISALIGN_TRAP_EN defined, an accepted H/HU at an odd address, W/WU with address[1:0]!=0, or D with address[2:0]!=0 SHALL be consumed without a memory request or FIFO push, and SHALL pulse o_misaligned for one cycle the next cycle.
REQ-029 Without RICE_CORE_LSU_MISALIGN_TRAP_EN, o_misaligned SHALL be constant 0, and the offset SHALL be forced to the access-size-aligned value (low bits truncated).

Verification
REQ-030 XLEN=32, SB at 0x1003 with data 0x000000A5 -> o_mem_address=0x1000, o_mem_strobe=4'b1000, o_mem_write_data=0xA5000000, no writeback.
REQ-031 XLEN=32, LB at 0x2001 with response 0x00008000 -> o_wb_data=0xFFFFFF80; LBU on the same data -> o_wb_data=0x00000080, each exactly one cycle after the response.
REQ-032 TRAP_EN defined, LH at 0x3001 -> o_misaligned=1 for one cycle, o_mem_request_valid stays 0, count stays 0.
REQ-033 MAX_OUTSTANDING=2, two loads issued with no response -> o_ready=0 for a third request; one response -> o_ready=1 the following cycle.
REQ-034 XLEN=64, LW at 0x4004 with response 0x8765432100000000 -> o_wb_data=0xFFFFFFFF87654321; LWU -> 0x0000000087654321.
REQ-035 i_rst asserted with 2 loads outstanding, then 1 response -> no o_wb_valid, o_ready=1 and count=0 after reset.

Source files
------------

// File: rtl/rice_core_lsu.sv
// rice_core_lsu: in-order load/store unit with one held memory request and a response-tracking FIFO.
// Defining RICE_CORE_LSU_MISALIGN_TRAP_EN traps misaligned accesses; otherwise their offsets are truncated.
module rice_core_lsu #(
    parameter int XLEN = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [1:0]          i_access_type,
    input  logic [2:0]          i_access_mode,
    input  logic [XLEN-1:0]     i_address,
    input  logic [XLEN-1:0]     i_store_data,
    input  logic [4:0]          i_rd,
    output logic                o_mem_request_valid,
    input  logic                i_mem_request_ready,
    output logic                o_mem_write,
    output logic [XLEN-1:0]     o_mem_address,
    output logic [XLEN/8-1:0]   o_mem_strobe,
    output logic [XLEN-1:0]     o_mem_write_data,
    input  logic                i_mem_response_valid,
    input  logic [XLEN-1:0]     i_mem_read_data,
    output logic                o_wb_valid,
    output logic [4:0]          o_wb_rd,
    output logic [XLEN-1:0]     o_wb_data,
    output logic                o_misaligned
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef struct packed {
        logic          write;
        logic [2:0]    mode;
        logic [OW-1:0] off;
        logic [4:0]    rd;
    } entry_t;

    logic [2:0]      mode;
    logic [1:0]      size;
    logic [OW-1:0]   lo;
    logic [NB-1:0]   bmask;
    logic [OW-1:0]   off;
    logic            is_mem;
    logic            accept;
    logic            push;
    logic            pop;
    logic            mis;
    logic            req_valid;
    logic            req_write;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [NB-1:0]   req_strobe;
    entry_t          fifo [4];
    logic [1:0]      wptr;
    logic [1:0]      rptr;
    logic [2:0]      cnt;
    entry_t          head;
    logic [1:0]      hsize;
    logic [6:0]      sh;
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] t;
    logic signed [XLEN-1:0] ts;
    logic            sgn;
    logic [XLEN-1:0] ext;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // On a 32-bit core D and WU collapse to a plain signed word.
    always_comb begin
        mode = (XLEN == 32 && (i_access_mode[1:0] == 2'b11 || i_access_mode == 3'b110)) ? 3'b010 : i_access_mode;
        size = mode[1:0];
        lo = OW'((4'd1 << size) - 4'd1);
        bmask = NB'((16'd1 << (5'd1 << size)) - 16'd1);
        off = i_address[OW-1:0] & ~lo;
    end

`ifdef RICE_CORE_LSU_MISALIGN_TRAP_EN
    assign mis = |(i_address[OW-1:0] & lo);
`else
    assign mis = 1'b0;
`endif

    assign o_ready = (cnt < 3'(MAX_OUTSTANDING)) && (!req_valid || i_mem_request_ready);
    assign is_mem = (i_access_type == 2'd1) || (i_access_type == 2'd2);
    assign accept = i_valid && o_ready;
    assign push = accept && is_mem && !mis;
    assign pop = i_mem_response_valid && (cnt != 3'd0);

    always_comb begin
        head = fifo[rptr];
        hsize = head.mode[1:0];
        sh = 7'(XLEN) - (7'd8 << hsize);
        s = i_mem_read_data >> {head.off, 3'b000};
        t = s << sh;
        ts = $signed(t) >>> sh;
        sgn = !head.mode[2] && (hsize != 2'b11);
        ext = sgn ? ts : t >> sh;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_valid <= 1'b0;
            wptr <= 2'd0;
            rptr <= 2'd0;
            cnt <= 3'd0;
            wb_valid <= 1'b0;
        end else begin
            if (push)
                req_valid <= 1'b1;
            else if (i_mem_request_ready)
                req_valid <= 1'b0;
            if (push)
                wptr <= nxt(wptr);
            if (pop)
                rptr <= nxt(rptr);
            cnt <= cnt + {2'b00, push} - {2'b00, pop};
            wb_valid <= pop && !head.write;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            req_write <= (i_access_type == 2'd1);
            req_addr <= {i_address[XLEN-1:OW], OW'(0)};
            req_strobe <= bmask << off;
            req_wdata <= i_store_data << {off, 3'b000};
            fifo[wptr] <= '{write: (i_access_type == 2'd1), mode: mode, off: off, rd: i_rd};
        end
        if (pop && !head.write) begin
            wb_rd <= head.rd;
            wb_data <= ext;
        end
    end

`ifdef RICE_CORE_LSU_MISALIGN_TRAP_EN
    logic mis_q;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            mis_q <= 1'b0;
        else
            mis_q <= accept && is_mem && mis;
    end
    assign o_misaligned = mis_q;
`else
    assign o_misaligned = 1'b0;
`endif

    assign o_mem_request_valid = req_valid;
    assign o_mem_write = req_write;
    assign o_mem_address = req_addr;
    assign o_mem_strobe = req_strobe;
    assign o_mem_write_data = req_wdata;
    assign o_wb_valid = wb_valid;
    assign o_wb_rd = wb_rd;
    assign o_wb_data = wb_data;
endmodule

// File: tb/tb_rice_core_lsu.sv
// tb_rice_core_lsu: directed table-driven checks of rice_core_lsu at XLEN=32 and XLEN=64.
module tb_rice_core_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        valid, ready, mreq_valid, mreq_ready, mwrite, mrsp_valid, wb_valid, misal;
    logic [1:0]  atype;
    logic [2:0]  amode;
    logic [31:0] addr, sdata, maddr, mwdata, mrdata, wb_data;
    logic [4:0]  rd, wb_rd;
    logic [3:0]  mstrobe;

    logic        q_valid, q_ready, q_mreq_valid, q_mreq_ready, q_mwrite, q_mrsp_valid, q_wb_valid, q_misal;
    logic [1:0]  q_atype;
    logic [2:0]  q_amode;
    logic [63:0] q_addr, q_sdata, q_maddr, q_mwdata, q_mrdata, q_wb_data;
    logic [4:0]  q_rd, q_wb_rd;
    logic [7:0]  q_mstrobe;

    rice_core_lsu #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_access_type(atype), .i_access_mode(amode), .i_address(addr),
        .i_store_data(sdata), .i_rd(rd), .o_mem_request_valid(mreq_valid),
        .i_mem_request_ready(mreq_ready), .o_mem_write(mwrite), .o_mem_address(maddr),
        .o_mem_strobe(mstrobe), .o_mem_write_data(mwdata), .i_mem_response_valid(mrsp_valid),
        .i_mem_read_data(mrdata), .o_wb_valid(wb_valid), .o_wb_rd(wb_rd),
        .o_wb_data(wb_data), .o_misaligned(misal)
    );

    rice_core_lsu #(.XLEN(64), .MAX_OUTSTANDING(2)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_valid(q_valid), .o_ready(q_ready),
        .i_access_type(q_atype), .i_access_mode(q_amode), .i_address(q_addr),
        .i_store_data(q_sdata), .i_rd(q_rd), .o_mem_request_valid(q_mreq_valid),
        .i_mem_request_ready(q_mreq_ready), .o_mem_write(q_mwrite), .o_mem_address(q_maddr),
        .o_mem_strobe(q_mstrobe), .o_mem_write_data(q_mwdata), .i_mem_response_valid(q_mrsp_valid),
        .i_mem_read_data(q_mrdata), .o_wb_valid(q_wb_valid), .o_wb_rd(q_wb_rd),
        .o_wb_data(q_wb_data), .o_misaligned(q_misal)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [2:0]  m;
        logic [31:0] a;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [31:0] rsp;
        logic [31:0] ea;
        logic [3:0]  es;
        logic [31:0] ew;
        logic        wb;
        logic [31:0] ed;
    } vec_t;

    typedef struct {
        logic [2:0]  m;
        logic [63:0] a;
        logic [63:0] rsp;
        logic [63:0] ea;
        logic [7:0]  es;
        logic [63:0] ed;
    } vec64_t;

    task automatic run32(input vec_t v, input int i);
        @(negedge clk);
        valid = 1'b1; atype = v.t; amode = v.m; addr = v.a; sdata = v.sd; rd = v.rd;
        check($sformatf("v%0d accept_ready", i), ready, 1);
        @(negedge clk);
        valid = 1'b0; atype = 2'd0;
        check($sformatf("v%0d req_valid", i), mreq_valid, 1);
        check($sformatf("v%0d misaligned", i), misal, 0);
        check($sformatf("v%0d ready_while_held", i), ready, 0);
        @(negedge clk);
        check($sformatf("v%0d req_held", i), mreq_valid, 1);
        check($sformatf("v%0d addr", i), maddr, v.ea);
        check($sformatf("v%0d strobe", i), mstrobe, v.es);
        check($sformatf("v%0d wdata", i), mwdata, v.ew);
        check($sformatf("v%0d write", i), mwrite, v.t == 2'd1);
        mreq_ready = 1'b1;
        @(negedge clk);
        mreq_ready = 1'b0;
        check($sformatf("v%0d req_drained", i), mreq_valid, 0);
        mrsp_valid = 1'b1; mrdata = v.rsp;
        @(negedge clk);
        mrsp_valid = 1'b0;
        check($sformatf("v%0d wb_valid", i), wb_valid, v.wb);
        if (v.wb) begin
            check($sformatf("v%0d wb_data", i), wb_data, v.ed);
            check($sformatf("v%0d wb_rd", i), wb_rd, v.rd);
        end
        @(negedge clk);
        check($sformatf("v%0d wb_pulse_end", i), wb_valid, 0);
    endtask

    task automatic run64(input vec64_t v, input int i);
        @(negedge clk);
        q_valid = 1'b1; q_atype = 2'd2; q_amode = v.m; q_addr = v.a; q_sdata = 64'd0; q_rd = 5'(i + 9);
        check($sformatf("q%0d accept_ready", i), q_ready, 1);
        @(negedge clk);
        q_valid = 1'b0; q_atype = 2'd0;
        check($sformatf("q%0d req_valid", i), q_mreq_valid, 1);
        check($sformatf("q%0d addr", i), q_maddr, v.ea);
        check($sformatf("q%0d strobe", i), q_mstrobe, v.es);
        check($sformatf("q%0d write", i), q_mwrite, 0);
        q_mreq_ready = 1'b1;
        @(negedge clk);
        q_mreq_ready = 1'b0;
        q_mrsp_valid = 1'b1; q_mrdata = v.rsp;
        @(negedge clk);
        q_mrsp_valid = 1'b0;
        check($sformatf("q%0d wb_valid", i), q_wb_valid, 1);
        check($sformatf("q%0d wb_data", i), q_wb_data, v.ed);
        check($sformatf("q%0d wb_rd", i), q_wb_rd, 5'(i + 9));
        @(negedge clk);
        check($sformatf("q%0d wb_pulse_end", i), q_wb_valid, 0);
    endtask

    // Two loads back to back with the memory always ready, leaving the FIFO full.
    task automatic fill_two;
        @(negedge clk);
        mreq_ready = 1'b1;
        valid = 1'b1; atype = 2'd2; amode = 3'b000; addr = 32'h2000; sdata = 0; rd = 5'd3;
        check("fill first_ready", ready, 1);
        @(negedge clk);
        amode = 3'b101; addr = 32'h2002; rd = 5'd4;
        check("fill second_ready", ready, 1);
        @(negedge clk);
        valid = 1'b0; atype = 2'd0;
        check("fill full_not_ready", ready, 0);
    endtask

    vec_t vt[11];
    vec64_t vq[4];

    initial begin
        vt[0]  = '{2'd1, 3'b000, 32'h1003, 32'h000000A5, 5'd1, 32'h0,        32'h1000, 4'b1000, 32'hA5000000, 1'b0, 32'h0};
        vt[1]  = '{2'd2, 3'b000, 32'h2001, 32'h0,        5'd2, 32'h00008000, 32'h2000, 4'b0010, 32'h0,        1'b1, 32'hFFFFFF80};
        vt[2]  = '{2'd2, 3'b100, 32'h2001, 32'h0,        5'd5, 32'h00008000, 32'h2000, 4'b0010, 32'h0,        1'b1, 32'h00000080};
        vt[3]  = '{2'd2, 3'b001, 32'h2002, 32'h0,        5'd6, 32'h80010000, 32'h2000, 4'b1100, 32'h0,        1'b1, 32'hFFFF8001};
        vt[4]  = '{2'd2, 3'b101, 32'h2002, 32'h0,        5'd7, 32'h80010000, 32'h2000, 4'b1100, 32'h0,        1'b1, 32'h00008001};
        vt[5]  = '{2'd2, 3'b010, 32'h2004, 32'h0,        5'd8, 32'hDEADBEEF, 32'h2004, 4'b1111, 32'h0,        1'b1, 32'hDEADBEEF};
        vt[6]  = '{2'd1, 3'b001, 32'h1002, 32'h00001234, 5'd9, 32'h0,        32'h1000, 4'b1100, 32'h12340000, 1'b0, 32'h0};
        vt[7]  = '{2'd1, 3'b010, 32'h1008, 32'hCAFEF00D, 5'd10, 32'h0,       32'h1008, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0};
        vt[8]  = '{2'd2, 3'b011, 32'h200C, 32'h0,        5'd11, 32'h80000001, 32'h200C, 4'b1111, 32'h0,       1'b1, 32'h80000001};
        vt[9]  = '{2'd1, 3'b000, 32'h1000, 32'h000001FF, 5'd12, 32'h0,       32'h1000, 4'b0001, 32'h000001FF, 1'b0, 32'h0};
        vt[10] = '{2'd2, 3'b000, 32'h2003, 32'h0,        5'd13, 32'h7F000000, 32'h2000, 4'b1000, 32'h0,       1'b1, 32'h0000007F};
        vq[0] = '{3'b010, 64'h4004, 64'h8765432100000000, 64'h4000, 8'hF0, 64'hFFFFFFFF87654321};
        vq[1] = '{3'b110, 64'h4004, 64'h8765432100000000, 64'h4000, 8'hF0, 64'h0000000087654321};
        vq[2] = '{3'b011, 64'h4008, 64'h8000000000000001, 64'h4008, 8'hFF, 64'h8000000000000001};
        vq[3] = '{3'b000, 64'h4007, 64'h8000000000000000, 64'h4000, 8'h80, 64'hFFFFFFFFFFFFFF80};

        rst = 1'b1;
        valid = 0; atype = 0; amode = 0; addr = 0; sdata = 0; rd = 0; mreq_ready = 0; mrsp_valid = 0; mrdata = 0;
        q_valid = 0; q_atype = 0; q_amode = 0; q_addr = 0; q_sdata = 0; q_rd = 0; q_mreq_ready = 0; q_mrsp_valid = 0; q_mrdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ready", ready, 1);
        check("reset req_valid", mreq_valid, 0);
        check("reset wb_valid", wb_valid, 0);
        check("reset misaligned", misal, 0);
        check("reset ready64", q_ready, 1);

        @(negedge clk);
        valid = 1'b1; atype = 2'd0; amode = 3'b010; addr = 32'h5000; rd = 5'd1;
        @(negedge clk);
        valid = 1'b0;
        check("none no_request", mreq_valid, 0);
        check("none ready", ready, 1);

        for (int i = 0; i < 11; i++) run32(vt[i], i);

`ifdef RICE_CORE_LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        valid = 1'b1; atype = 2'd2; amode = 3'b001; addr = 32'h3001; rd = 5'd2;
        check("trap accept_ready", ready, 1);
        @(negedge clk);
        valid = 1'b0; atype = 2'd0;
        check("trap misaligned", misal, 1);
        check("trap no_request", mreq_valid, 0);
        @(negedge clk);
        check("trap pulse_end", misal, 0);
        check("trap still_no_request", mreq_valid, 0);
        mrsp_valid = 1'b1; mrdata = 32'hFFFFFFFF;
        @(negedge clk);
        mrsp_valid = 1'b0;
        check("trap count_zero_no_wb", wb_valid, 0);
`else
        begin
            vec_t mv;
            mv = '{2'd2, 3'b001, 32'h3001, 32'h0, 5'd14, 32'h0000FF80, 32'h3000, 4'b0011, 32'h0, 1'b1, 32'hFFFFFF80};
            run32(mv, 11);
        end
`endif

        fill_two();
        mrsp_valid = 1'b1; mrdata = 32'h000000FF;
        @(negedge clk);
        mreq_ready = 1'b0;
        check("full ready_after_response", ready, 1);
        check("full wb1_valid", wb_valid, 1);
        check("full wb1_data", wb_data, 32'hFFFFFFFF);
        check("full wb1_rd", wb_rd, 5'd3);
        mrdata = 32'hBEEF0000;
        @(negedge clk);
        check("full wb2_valid", wb_valid, 1);
        check("full wb2_data", wb_data, 32'h0000BEEF);
        check("full wb2_rd", wb_rd, 5'd4);
        mrdata = 32'h12345678;
        @(negedge clk);
        mrsp_valid = 1'b0;
        check("empty response_ignored", wb_valid, 0);
        check("empty ready", ready, 1);

        fill_two();
        mreq_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst ready", ready, 1);
        check("rst req_cleared", mreq_valid, 0);
        mrsp_valid = 1'b1; mrdata = 32'h000000FF;
        @(negedge clk);
        mrsp_valid = 1'b0;
        check("rst stale_no_wb", wb_valid, 0);
        check("rst ready_after", ready, 1);
        mreq_ready = 1'b1;
        valid = 1'b1; atype = 2'd2; amode = 3'b000; addr = 32'h2000; rd = 5'd5;
        @(negedge clk);
        amode = 3'b000; addr = 32'h2001; rd = 5'd6;
        check("rst count_was_zero", ready, 1);
        @(negedge clk);
        valid = 1'b0; atype = 2'd0; mreq_ready = 1'b0;
        check("rst refill_full", ready, 0);

        for (int i = 0; i < 4; i++) run64(vq[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
